hmu_agent_arb: RTL and testbench

- Upstream front-end of the hierarchical memory unit. It merges request streams from NUM_AGENTS agents into the single HMU request port and routes HMU responses back to the originating agent.
- Round-robin arbitration, per-agent outstanding-credit limit, ID tagging ({agent, tag} → 6-bit req_id), and a drain handshake used before tier migration or power-down.
- The HMU port has no backpressure, so this block is the only flow-control point in front of it.

---
 rtl/hmu_agent_arb.sv | 157 +++++++++++++++
 tb/tb_hmu_agent_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmu_agent_arb.sv
// hmu_agent_arb: round-robin front-end merging agent request streams into the HMU port
// with per-agent credit limits, {agent,tag} id tagging, response routing and a drain handshake.
module hmu_agent_arb #(
    parameter int NUM_AGENTS      = 4,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int TAG_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AGT_W          = $clog2(NUM_AGENTS),
    localparam int ID_W           = AGT_W + TAG_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_AGENTS-1:0]            agt_req_valid,
    output logic [NUM_AGENTS-1:0]            agt_req_ready,
    input  logic [NUM_AGENTS*ADDR_WIDTH-1:0] agt_req_addr,
    input  logic [NUM_AGENTS*DATA_WIDTH-1:0] agt_req_data,
    input  logic [NUM_AGENTS-1:0]            agt_req_we,
    output logic [NUM_AGENTS-1:0]            agt_rsp_valid,
    output logic [DATA_WIDTH-1:0]            agt_rsp_data,
    output logic [TAG_WIDTH-1:0]             agt_rsp_tag,
    output logic                             hmu_req_valid,
    output logic [ADDR_WIDTH-1:0]            hmu_req_addr,
    output logic [DATA_WIDTH-1:0]            hmu_req_data,
    output logic                             hmu_req_we,
    output logic [ID_W-1:0]                  hmu_req_id,
    input  logic                             hmu_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            hmu_rsp_data,
    input  logic [ID_W-1:0]                  hmu_rsp_id,
    input  logic                             hmu_stall,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic                             err_stray
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t                  state_q, state_d;
    logic [AGT_W-1:0]        rr_q;
    logic [TAG_WIDTH-1:0]    tag_q [NUM_AGENTS];
    logic [CNT_W-1:0]        out_q [NUM_AGENTS];
    logic [CNT_W-1:0]        out_d [NUM_AGENTS];
    logic [NUM_AGENTS-1:0]   elig, gnt;
    logic [AGT_W-1:0]        gnt_idx, idx;
    logic                    found, can_grant, xfer;
    logic [AGT_W-1:0]        rsp_agt;
    logic                    rsp_stray, rsp_ok, all_idle;

    logic                    req_vld_q, req_we_q, err_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q, rsp_data_q;
    logic [ID_W-1:0]         req_id_q;
    logic [NUM_AGENTS-1:0]   rsp_vld_q;
    logic [TAG_WIDTH-1:0]    rsp_tag_q;

    assign can_grant = !hmu_stall && state_q == RUN && !drain_req;

    always_comb begin
        for (int i = 0; i < NUM_AGENTS; i++)
            elig[i] = agt_req_valid[i] && (out_q[i] < CNT_W'(MAX_OUTSTANDING));
    end

    // first eligible agent at or after rr_q; the AGT_W-wide sum wraps naturally
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_AGENTS; k++) begin
            idx = rr_q + AGT_W'(k);
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && can_grant)
            gnt[gnt_idx] = 1'b1;
    end

    assign agt_req_ready = gnt;
    assign xfer          = |gnt;

    assign rsp_agt   = hmu_rsp_id[ID_W-1:TAG_WIDTH];
    assign rsp_stray = hmu_rsp_valid && out_q[rsp_agt] == '0;
    assign rsp_ok    = hmu_rsp_valid && !rsp_stray;

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            out_d[i] = out_q[i] + CNT_W'(gnt[i]) - CNT_W'(rsp_ok && rsp_agt == AGT_W'(i));
            if (out_q[i] != '0)
                all_idle = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = drain_req ? DRAIN : RUN;
            DRAIN:   state_d = !drain_req ? RUN : (all_idle && !req_vld_q) ? DRAINED : DRAIN;
            DRAINED: state_d = drain_req ? DRAINED : RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            rr_q       <= '0;
            req_vld_q  <= 1'b0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_id_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_AGENTS; i++) begin
                tag_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_vld_q <= xfer;
            err_q     <= rsp_stray;
            rsp_vld_q <= rsp_ok ? NUM_AGENTS'(1) << rsp_agt : '0;
            for (int i = 0; i < NUM_AGENTS; i++)
                out_q[i] <= out_d[i];
            if (xfer) begin
                rr_q           <= gnt_idx + AGT_W'(1);
                req_addr_q     <= agt_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                req_data_q     <= agt_req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                req_we_q       <= agt_req_we[gnt_idx];
                req_id_q       <= {gnt_idx, tag_q[gnt_idx]};
                tag_q[gnt_idx] <= tag_q[gnt_idx] + TAG_WIDTH'(1);
            end
            if (rsp_ok) begin
                rsp_data_q <= hmu_rsp_data;
                rsp_tag_q  <= hmu_rsp_id[TAG_WIDTH-1:0];
            end
        end
    end

    assign hmu_req_valid = req_vld_q;
    assign hmu_req_addr  = req_addr_q;
    assign hmu_req_data  = req_data_q;
    assign hmu_req_we    = req_we_q;
    assign hmu_req_id    = req_id_q;
    assign agt_rsp_valid = rsp_vld_q;
    assign agt_rsp_data  = rsp_data_q;
    assign agt_rsp_tag   = rsp_tag_q;
    assign err_stray     = err_q;
    assign drain_done    = state_q == DRAINED;

endmodule

// File: tb/tb_hmu_agent_arb.sv
// tb_hmu_agent_arb: directed scenario bench for hmu_agent_arb with hand-computed expectations.
module tb_hmu_agent_arb;
    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    agt_req_valid;
    logic [N-1:0]    agt_req_ready;
    logic [N*AW-1:0] agt_req_addr;
    logic [N*DW-1:0] agt_req_data;
    logic [N-1:0]    agt_req_we;
    logic [N-1:0]    agt_rsp_valid;
    logic [DW-1:0]   agt_rsp_data;
    logic [TW-1:0]   agt_rsp_tag;
    logic            hmu_req_valid;
    logic [AW-1:0]   hmu_req_addr;
    logic [DW-1:0]   hmu_req_data;
    logic            hmu_req_we;
    logic [5:0]      hmu_req_id;
    logic            hmu_rsp_valid;
    logic [DW-1:0]   hmu_rsp_data;
    logic [5:0]      hmu_rsp_id;
    logic            hmu_stall;
    logic            drain_req;
    logic            drain_done;
    logic            err_stray;

    int chk = 0;
    int pass = 0;

    hmu_agent_arb dut (
        .clk(clk), .rst_n(rst_n),
        .agt_req_valid(agt_req_valid), .agt_req_ready(agt_req_ready),
        .agt_req_addr(agt_req_addr), .agt_req_data(agt_req_data), .agt_req_we(agt_req_we),
        .agt_rsp_valid(agt_rsp_valid), .agt_rsp_data(agt_rsp_data), .agt_rsp_tag(agt_rsp_tag),
        .hmu_req_valid(hmu_req_valid), .hmu_req_addr(hmu_req_addr), .hmu_req_data(hmu_req_data),
        .hmu_req_we(hmu_req_we), .hmu_req_id(hmu_req_id),
        .hmu_rsp_valid(hmu_rsp_valid), .hmu_rsp_data(hmu_rsp_data), .hmu_rsp_id(hmu_rsp_id),
        .hmu_stall(hmu_stall), .drain_req(drain_req), .drain_done(drain_done), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        agt_req_valid = '0;
        agt_req_addr  = '0;
        agt_req_data  = '0;
        agt_req_we    = '0;
        hmu_rsp_valid = 1'b0;
        hmu_rsp_data  = '0;
        hmu_rsp_id    = '0;
        hmu_stall     = 1'b0;
        drain_req     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        chk++; if ({agt_req_ready, agt_rsp_valid, hmu_req_valid, hmu_req_we, hmu_req_id, drain_done, err_stray} !== '0)
            $display("FAIL reset_ctl got=%h exp=0", {agt_req_ready, agt_rsp_valid, hmu_req_valid, hmu_req_we, hmu_req_id, drain_done, err_stray}); else pass++;
        chk++; if (hmu_req_addr !== '0) $display("FAIL reset_addr got=%h exp=0", hmu_req_addr); else pass++;
        chk++; if (hmu_req_data !== '0 || agt_rsp_data !== '0) $display("FAIL reset_data got=%h/%h exp=0", hmu_req_data, agt_rsp_data); else pass++;
        chk++; if (agt_rsp_tag !== '0) $display("FAIL reset_tag got=%h exp=0", agt_rsp_tag); else pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = {16{32'hCAFE_0001}};
        agt_req_valid = 4'b0001;
        agt_req_addr[0 +: AW] = 48'h0000_1000;
        #1;
        chk++; if (agt_req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", agt_req_ready); else pass++;
        tick();
        agt_req_valid = '0;
        chk++; if (hmu_req_valid !== 1'b1 || hmu_req_id !== 6'h00) $display("FAIL single_issue got=%b/%h exp=1/00", hmu_req_valid, hmu_req_id); else pass++;
        chk++; if (hmu_req_addr !== 48'h1000 || hmu_req_we !== 1'b0) $display("FAIL single_addr got=%h/%b exp=1000/0", hmu_req_addr, hmu_req_we); else pass++;
        tick();
        chk++; if (hmu_req_valid !== 1'b0) $display("FAIL single_strobe_len got=%b exp=0", hmu_req_valid); else pass++;
        tick();
        hmu_rsp_valid = 1'b1; hmu_rsp_id = 6'h00; hmu_rsp_data = d;
        tick();
        hmu_rsp_valid = 1'b0;
        chk++; if (agt_rsp_valid !== 4'b0001 || agt_rsp_tag !== 4'h0) $display("FAIL single_rsp got=%b/%h exp=0001/0", agt_rsp_valid, agt_rsp_tag); else pass++;
        chk++; if (agt_rsp_data !== d) $display("FAIL single_rsp_data got=%h exp=%h", agt_rsp_data, d); else pass++;
        tick();
        chk++; if (agt_rsp_valid !== 4'b0000 || agt_rsp_data !== d) $display("FAIL single_rsp_hold got=%b/%h exp=0000/%h", agt_rsp_valid, agt_rsp_data, d); else pass++;
    endtask

    task automatic test_round_robin();
        int a;
        logic [5:0]    eid;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        do_reset();
        for (int i = 0; i < N; i++) begin
            agt_req_addr[i*AW +: AW] = 48'h1000 * (i + 1);
            agt_req_data[i*DW +: DW] = {16{32'(32'hA0 + i)}};
        end
        agt_req_we    = 4'b1010;
        agt_req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 16; g++) begin
            a     = g % 4;
            eid   = 6'(a * 16 + g / 4);
            eaddr = 48'h1000 * (a + 1);
            edata = {16{32'(32'hA0 + a)}};
            chk++; if (agt_req_ready !== 4'(1 << a)) $display("FAIL rr_ready g=%0d got=%b exp=%b", g, agt_req_ready, 4'(1 << a)); else pass++;
            tick();
            chk++; if (hmu_req_valid !== 1'b1 || hmu_req_id !== eid) $display("FAIL rr_id g=%0d got=%b/%h exp=1/%h", g, hmu_req_valid, hmu_req_id, eid); else pass++;
            chk++; if (hmu_req_addr !== eaddr || hmu_req_we !== a[0] || hmu_req_data !== edata)
                $display("FAIL rr_payload g=%0d got=%h/%b exp=%h/%b", g, hmu_req_addr, hmu_req_we, eaddr, a[0]); else pass++;
        end
        chk++; if (agt_req_ready !== 4'b0000) $display("FAIL rr_credit_cap got=%b exp=0000", agt_req_ready); else pass++;
        tick();
        chk++; if (hmu_req_valid !== 1'b0) $display("FAIL rr_no_issue got=%b exp=0", hmu_req_valid); else pass++;
    endtask

    task automatic test_credit_return();
        agt_req_valid = 4'b0100;
        hmu_rsp_valid = 1'b1; hmu_rsp_id = 6'h21; hmu_rsp_data = {16{32'h1111_2222}};
        #1;
        chk++; if (agt_req_ready !== 4'b0000) $display("FAIL credit_full got=%b exp=0000", agt_req_ready); else pass++;
        tick();
        hmu_rsp_id = 6'h22;
        chk++; if (agt_rsp_valid !== 4'b0100 || agt_rsp_tag !== 4'h1) $display("FAIL credit_rsp1 got=%b/%h exp=0100/1", agt_rsp_valid, agt_rsp_tag); else pass++;
        chk++; if (agt_req_ready !== 4'b0100) $display("FAIL credit_regrant got=%b exp=0100", agt_req_ready); else pass++;
        tick();
        hmu_rsp_valid = 1'b0;
        chk++; if (hmu_req_valid !== 1'b1 || hmu_req_id !== 6'h24) $display("FAIL credit_issue1 got=%b/%h exp=1/24", hmu_req_valid, hmu_req_id); else pass++;
        chk++; if (agt_rsp_valid !== 4'b0100 || agt_rsp_tag !== 4'h2) $display("FAIL credit_rsp2 got=%b/%h exp=0100/2", agt_rsp_valid, agt_rsp_tag); else pass++;
        chk++; if (agt_req_ready !== 4'b0100) $display("FAIL credit_net_zero got=%b exp=0100", agt_req_ready); else pass++;
        tick();
        chk++; if (hmu_req_id !== 6'h25) $display("FAIL credit_issue2 got=%h exp=25", hmu_req_id); else pass++;
        chk++; if (agt_req_ready !== 4'b0000) $display("FAIL credit_refull got=%b exp=0000", agt_req_ready); else pass++;
        agt_req_valid = '0;
    endtask

    task automatic test_stray_and_stall();
        do_reset();
        hmu_rsp_valid = 1'b1; hmu_rsp_id = 6'h35; hmu_rsp_data = {16{32'hDEAD_BEEF}};
        tick();
        hmu_rsp_valid = 1'b0;
        chk++; if (err_stray !== 1'b1 || agt_rsp_valid !== 4'b0000) $display("FAIL stray_pulse got=%b/%b exp=1/0000", err_stray, agt_rsp_valid); else pass++;
        chk++; if (agt_rsp_tag !== 4'h0 || agt_rsp_data !== '0) $display("FAIL stray_dropped got=%h exp=0", agt_rsp_tag); else pass++;
        tick();
        chk++; if (err_stray !== 1'b0) $display("FAIL stray_len got=%b exp=0", err_stray); else pass++;
        hmu_stall = 1'b1;
        agt_req_valid = 4'b1000;
        #1;
        chk++; if (agt_req_ready !== 4'b0000) $display("FAIL stall_block got=%b exp=0000", agt_req_ready); else pass++;
        hmu_stall = 1'b0;
        #1;
        chk++; if (agt_req_ready !== 4'b1000) $display("FAIL stray_no_underflow got=%b exp=1000", agt_req_ready); else pass++;
        agt_req_valid = '0;
    endtask

    task automatic test_drain();
        do_reset();
        agt_req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk++; if (agt_req_ready !== 4'b0001) $display("FAIL drain_fill i=%0d got=%b exp=0001", i, agt_req_ready); else pass++;
            tick();
        end
        drain_req = 1'b1;
        agt_req_valid = 4'b0010;
        #1;
        chk++; if (agt_req_ready !== 4'b0000) $display("FAIL drain_same_cycle got=%b exp=0000", agt_req_ready); else pass++;
        tick();
        chk++; if (agt_req_ready !== 4'b0000 || drain_done !== 1'b0) $display("FAIL drain_block got=%b/%b exp=0000/0", agt_req_ready, drain_done); else pass++;
        for (int t = 0; t < 3; t++) begin
            hmu_rsp_valid = 1'b1; hmu_rsp_id = 6'(t);
            tick();
        end
        hmu_rsp_valid = 1'b0;
        chk++; if (agt_rsp_valid !== 4'b0001 || agt_rsp_tag !== 4'h2 || drain_done !== 1'b0)
            $display("FAIL drain_last_rsp got=%b/%h/%b exp=0001/2/0", agt_rsp_valid, agt_rsp_tag, drain_done); else pass++;
        tick();
        chk++; if (drain_done !== 1'b1 || agt_req_ready !== 4'b0000) $display("FAIL drain_done got=%b/%b exp=1/0000", drain_done, agt_req_ready); else pass++;
        drain_req = 1'b0;
        #1;
        chk++; if (agt_req_ready !== 4'b0000 || drain_done !== 1'b1) $display("FAIL drain_release got=%b/%b exp=0000/1", agt_req_ready, drain_done); else pass++;
        tick();
        chk++; if (drain_done !== 1'b0 || agt_req_ready !== 4'b0010) $display("FAIL drain_resume got=%b/%b exp=0/0010", drain_done, agt_req_ready); else pass++;
        agt_req_valid = '0;
    endtask

    task automatic test_tag_wrap_and_reset();
        logic [5:0] eid;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            eid = 6'(16 + n % 16);
            agt_req_valid = 4'b0010;
            #1;
            chk++; if (agt_req_ready !== 4'b0010) $display("FAIL wrap_ready n=%0d got=%b exp=0010", n, agt_req_ready); else pass++;
            tick();
            agt_req_valid = '0;
            chk++; if (hmu_req_id !== eid) $display("FAIL wrap_id n=%0d got=%h exp=%h", n, hmu_req_id, eid); else pass++;
            hmu_rsp_valid = 1'b1; hmu_rsp_id = eid;
            tick();
            hmu_rsp_valid = 1'b0;
            chk++; if (agt_rsp_valid !== 4'b0010 || agt_rsp_tag !== eid[3:0]) $display("FAIL wrap_rsp n=%0d got=%b/%h exp=0010/%h", n, agt_rsp_valid, agt_rsp_tag, eid[3:0]); else pass++;
        end
        agt_req_valid = 4'b0010;
        tick();
        agt_req_valid = '0;
        chk++; if (hmu_req_valid !== 1'b1 || hmu_req_id !== 6'h14) $display("FAIL midrst_pre got=%b/%h exp=1/14", hmu_req_valid, hmu_req_id); else pass++;
        rst_n = 1'b0;
        #1;
        chk++; if ({agt_rsp_valid, hmu_req_valid, hmu_req_we, hmu_req_id, drain_done, err_stray, agt_rsp_tag} !== '0)
            $display("FAIL midrst_ctl got=%h exp=0", {agt_rsp_valid, hmu_req_valid, hmu_req_we, hmu_req_id, drain_done, err_stray, agt_rsp_tag}); else pass++;
        chk++; if (agt_rsp_data !== '0 || hmu_req_addr !== '0) $display("FAIL midrst_data got=%h exp=0", hmu_req_addr); else pass++;
        rst_n = 1'b1;
        agt_req_valid = 4'b1111;
        #1;
        chk++; if (agt_req_ready !== 4'b0001) $display("FAIL midrst_rr got=%b exp=0001", agt_req_ready); else pass++;
        tick();
        agt_req_valid = '0;
        chk++; if (hmu_req_valid !== 1'b1 || hmu_req_id !== 6'h00) $display("FAIL midrst_id got=%b/%h exp=1/00", hmu_req_valid, hmu_req_id); else pass++;
        hmu_rsp_valid = 1'b1; hmu_rsp_id = 6'h14;
        tick();
        hmu_rsp_valid = 1'b0;
        chk++; if (err_stray !== 1'b1 || agt_rsp_valid !== 4'b0000) $display("FAIL midrst_stray got=%b/%b exp=1/0000", err_stray, agt_rsp_valid); else pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit_return();
        test_stray_and_stall();
        test_drain();
        test_tag_wrap_and_reset();
        tick();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
